// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// The word address addr[17:2] is split as {tag, index, offset}, matching the BRAM block layout.
package icache_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int TAG_WIDTH    = 8;
  localparam int INDEX_WIDTH  = 3;
  localparam int OFFSET_WIDTH = 5;
  localparam int LINES        = 1 << INDEX_WIDTH;
  localparam int WORDS        = 1 << OFFSET_WIDTH;
  localparam int RAM_AW       = INDEX_WIDTH + OFFSET_WIDTH;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  idx;
    logic [OFFSET_WIDTH-1:0] off;
  } addr_fields_t;

  // Takes word-address bits addr[17:2].
  function automatic addr_fields_t split_addr(input logic [TAG_WIDTH+RAM_AW-1:0] waddr);
    return addr_fields_t'(waddr);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and controller-side signals of the instruction cache.
// The cache uses the slave view; the CPU/controller environment uses the master view.
interface icache_if;

  logic                              cpu_req;
  logic [31:0]                       cpu_addr;
  logic                              cpu_flush;
  logic                              cpu_ready;
  logic [icache_pkg::DATA_WIDTH-1:0] cpu_data;

  logic                              mem_enable;
  logic                              mem_rw;
  logic                              mem_op_size;
  logic                              mem_finishes_op;
  logic [31:0]                       mem_addr;
  logic [icache_pkg::DATA_WIDTH-1:0] mem_data_read;
  logic                              mem_data_read_valid;
  logic                              mem_finished;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush,
    input  mem_data_read, mem_data_read_valid, mem_finished,
    output cpu_ready, cpu_data,
    output mem_enable, mem_rw, mem_op_size, mem_finishes_op, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flush,
    output mem_data_read, mem_data_read_valid, mem_finished,
    input  cpu_ready, cpu_data,
    input  mem_enable, mem_rw, mem_op_size, mem_finishes_op, mem_addr
  );

endinterface

// File: rtl/icache_line_ram.sv
// Cache data store: 8 lines x 32 words, addressed {idx, off}.
// Synchronous write for the refill stream, asynchronous read so hits return in the request cycle.
module icache_line_ram
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [RAM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [RAM_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; misses fetch a whole 32-word line
// from the block controller and fill it from the returned word stream.
module icache
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  icache_if.slave  bus
);

  state_t                  state_reg, state_next;
  addr_fields_t            req_f;
  logic [LINES-1:0]        valid_reg;
  logic [TAG_WIDTH-1:0]    tag_reg [LINES];
  logic [TAG_WIDTH-1:0]    miss_tag_reg;
  logic [INDEX_WIDTH-1:0]  miss_idx_reg;
  logic [OFFSET_WIDTH:0]   wcnt_reg;
  logic                    flush_pend_reg;
  logic                    mem_enable_reg;
  logic [31:0]             mem_addr_reg;
  logic                    hit, start_miss, cpu_ready, fill_we, fill_commit, flush_now;
  logic                    unused_addr_bits;

  assign req_f            = split_addr(bus.cpu_addr[17:2]);
  assign unused_addr_bits = ^{bus.cpu_addr[31:18], bus.cpu_addr[1:0]};
  assign hit              = valid_reg[req_f.idx] && (tag_reg[req_f.idx] == req_f.tag);
  assign flush_now        = flush_pend_reg || bus.cpu_flush;
  // wcnt saturates at 32: its top bit blocks any surplus words from the controller.
  assign fill_we     = (state_reg == REFILL) && bus.mem_data_read_valid && !wcnt_reg[OFFSET_WIDTH];
  assign fill_commit = (state_reg == REFILL) && bus.mem_finished && !flush_now;

  always_comb begin
    state_next = state_reg;
    cpu_ready  = 1'b0;
    start_miss = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cpu_req && !bus.cpu_flush) begin
          cpu_ready  = hit;
          start_miss = !hit;
          if (!hit) state_next = REFILL;
        end
      end
      REFILL:  if (bus.mem_finished) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= '0;
      miss_tag_reg   <= '0;
      miss_idx_reg   <= '0;
      wcnt_reg       <= '0;
      flush_pend_reg <= 1'b0;
      mem_enable_reg <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      mem_enable_reg <= start_miss;
      if (start_miss) begin
        miss_tag_reg <= req_f.tag;
        miss_idx_reg <= req_f.idx;
        wcnt_reg     <= '0;
        mem_addr_reg <= {14'b0, req_f.tag, req_f.idx, 7'b0};
      end else if (fill_we) begin
        wcnt_reg <= wcnt_reg + 1'b1;
      end

      if (state_reg == IDLE && bus.cpu_flush)   valid_reg <= '0;
      else if (start_miss)                      valid_reg[req_f.idx] <= 1'b0;
      else if (fill_commit)                     valid_reg[miss_idx_reg] <= 1'b1;
      else if (state_reg == DONE && flush_now)  valid_reg <= '0;

      // A flush seen while busy is deferred to the DONE->IDLE transition.
      if (state_reg == DONE)                          flush_pend_reg <= 1'b0;
      else if (state_reg == REFILL && bus.cpu_flush)  flush_pend_reg <= 1'b1;
    end
  end

  // Tags are deliberately left unreset; valid bits alone qualify them.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (fill_commit && miss_idx_reg == INDEX_WIDTH'(gi)) tag_reg[gi] <= miss_tag_reg;
    end
  end

  icache_line_ram u_ram (
    .clk   (clk),
    .we    (fill_we),
    .waddr ({miss_idx_reg, wcnt_reg[OFFSET_WIDTH-1:0]}),
    .wdata (bus.mem_data_read),
    .raddr ({req_f.idx, req_f.off}),
    .rdata (bus.cpu_data)
  );

  assign bus.cpu_ready       = cpu_ready;
  assign bus.mem_enable      = mem_enable_reg;
  assign bus.mem_addr        = mem_addr_reg;
  assign bus.mem_rw          = MEM_READ;
  assign bus.mem_op_size     = 1'b0;
  assign bus.mem_finishes_op = 1'b0;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a table of fetches with hand-computed results,
// followed by hand-written flush and reset-during-refill sequences.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  icache_if bus ();

  icache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          nwords;
    bit          miss;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Controller model payload: word k of the block at byte address baddr.
  function automatic logic [31:0] mem_word(input logic [31:0] baddr, input int k);
    return baddr + 32'h9F00 + 32'(k);
  endfunction

  task automatic clear_mem_inputs();
    bus.mem_data_read_valid = 1'b0;
    bus.mem_data_read       = '0;
    bus.mem_finished        = 1'b0;
    bus.cpu_flush           = 1'b0;
  endtask

  // Issues one fetch and plays the controller: 3 idle cycles after mem_enable,
  // nwords streamed words, then a mem_finished pulse. flush_at is an absolute cycle
  // number within the fetch (-1 = none); hold=0 drops cpu_req after the first cycle.
  task automatic fetch(input logic [31:0] a, input int nwords, input bit hold, input int flush_at,
                       output logic [31:0] data, output bit missed, output int n_en,
                       output logic [31:0] en_addr, output int lat);
    int  start = -1;
    int  k     = 0;
    int  fin   = -1;
    bit  done  = 1'b0;
    data = '0; missed = 1'b0; n_en = 0; en_addr = '0; lat = -1;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1 && !hold) bus.cpu_req = 1'b0;
      if (bus.mem_enable) begin
        n_en++; en_addr = bus.mem_addr; start = c; k = 0; fin = -1;
      end
      clear_mem_inputs();
      bus.cpu_flush = (c == flush_at);
      if (start >= 0 && fin < 0 && c >= start + 3) begin
        if (k < nwords) begin
          bus.mem_data_read_valid = 1'b1;
          bus.mem_data_read       = mem_word(en_addr, k);
          k++;
        end else begin
          bus.mem_finished = 1'b1;
          fin = c;
        end
      end
      #1;
      if (bus.cpu_ready) begin
        data = bus.cpu_data; missed = (c > 0); lat = (fin >= 0) ? c - fin : -1; done = 1'b1;
      end else if (!hold && fin >= 0 && c == fin + 2) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL fetch_timeout: addr %h got no completion, expected one within 400 cycles", a);
    end
    @(negedge clk);
    if (bus.mem_enable) n_en++;
    bus.cpu_req = 1'b0;
    clear_mem_inputs();
  endtask

  logic [31:0] f_data, f_en_addr;
  bit          f_missed;
  int          f_n_en, f_lat;

  initial begin
    rst_n = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    clear_mem_inputs();

    vecs[0] = '{32'h0000_0100, 32, 1'b1, 32'h0000_A000};
    vecs[1] = '{32'h0000_017C, 32, 1'b0, 32'h0000_A01F};
    vecs[2] = '{32'h0000_0104, 32, 1'b0, 32'h0000_A001};
    vecs[3] = '{32'hFFFC_0143, 32, 1'b0, 32'h0000_A010};
    vecs[4] = '{32'h0000_0500, 32, 1'b1, 32'h0000_A400};
    vecs[5] = '{32'h0000_0544, 32, 1'b0, 32'h0000_A411};
    vecs[6] = '{32'h0000_0100, 32, 1'b1, 32'h0000_A000};
    vecs[7] = '{32'h0000_0C00, 34, 1'b1, 32'h0000_AB00};
    vecs[8] = '{32'h0000_0C7C, 32, 1'b0, 32'h0000_AB1F};
    vecs[9] = '{32'h0000_017C, 32, 1'b0, 32'h0000_A01F};

    repeat (3) @(negedge clk);
    check("reset_mem_enable", 32'(bus.mem_enable), 32'h0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cpu_ready", 32'(bus.cpu_ready), 32'h0);
    check("mem_rw", 32'(bus.mem_rw), 32'h0);
    check("mem_op_size", 32'(bus.mem_op_size), 32'h0);
    check("mem_finishes_op", 32'(bus.mem_finishes_op), 32'h0);

    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].addr, vecs[i].nwords, 1'b1, -1, f_data, f_missed, f_n_en, f_en_addr, f_lat);
      $display("fetch %0d addr=%h miss=%0d enables=%0d data=%h", i, vecs[i].addr, f_missed, f_n_en, f_data);
      check($sformatf("v%0d_miss", i), 32'(f_missed), 32'(vecs[i].miss));
      check($sformatf("v%0d_data", i), f_data, vecs[i].data);
      check($sformatf("v%0d_enables", i), 32'(f_n_en), vecs[i].miss ? 32'd1 : 32'd0);
      if (vecs[i].miss) begin
        check($sformatf("v%0d_mem_addr", i), f_en_addr, vecs[i].addr & 32'h0003_FF80);
        check($sformatf("v%0d_ready_lat", i), 32'(f_lat), 32'd2);
      end
    end

    // Flush mid-refill with cpu_req dropped: fill completes but nothing stays valid.
    fetch(32'h0000_0500, 32, 1'b0, 10, f_data, f_missed, f_n_en, f_en_addr, f_lat);
    $display("refill 0x500 with flush, enables=%0d", f_n_en);
    check("flush_refill_enables", 32'(f_n_en), 32'd1);
    check("flush_refill_valid", 32'(dut.valid_reg), 32'h0);
    check("flush_refill_state", 32'(dut.state_reg), 32'(IDLE));
    fetch(32'h0000_0500, 32, 1'b1, -1, f_data, f_missed, f_n_en, f_en_addr, f_lat);
    $display("fetch after flushed refill addr=00000500 miss=%0d data=%h", f_missed, f_data);
    check("post_flush_miss", 32'(f_missed), 32'd1);
    check("post_flush_data", f_data, 32'h0000_A400);

    // Flush in IDLE suppresses a would-be hit and empties the cache.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0500; bus.cpu_flush = 1'b1;
    #1;
    check("idle_flush_ready", 32'(bus.cpu_ready), 32'h0);
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_flush = 1'b0;
    check("idle_flush_valid", 32'(dut.valid_reg), 32'h0);
    check("idle_flush_enable", 32'(bus.mem_enable), 32'h0);
    $display("idle flush done");
    fetch(32'h0000_0500, 32, 1'b1, -1, f_data, f_missed, f_n_en, f_en_addr, f_lat);
    check("idle_flush_refetch_miss", 32'(f_missed), 32'd1);

    // Reset during a refill abandons it.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0900;
    @(negedge clk);
    check("rst_seq_enable", 32'(bus.mem_enable), 32'h1);
    check("rst_seq_addr", bus.mem_addr, 32'h0000_0900);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bus.mem_data_read_valid = 1'b1;
      bus.mem_data_read       = mem_word(32'h0000_0900, k);
      @(negedge clk);
    end
    clear_mem_inputs();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_enable", 32'(bus.mem_enable), 32'h0);
    check("rst_mid_state", 32'(dut.state_reg), 32'(IDLE));
    check("rst_mid_valid", 32'(dut.valid_reg), 32'h0);
    check("rst_mid_wcnt", 32'(dut.wcnt_reg), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-refill released");
    fetch(32'h0000_0500, 32, 1'b1, -1, f_data, f_missed, f_n_en, f_en_addr, f_lat);
    $display("fetch after reset addr=00000500 miss=%0d enables=%0d data=%h", f_missed, f_n_en, f_data);
    check("post_rst_miss", 32'(f_missed), 32'd1);
    check("post_rst_enables", 32'(f_n_en), 32'd1);
    check("post_rst_data", f_data, 32'h0000_A400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
